fpu_issue_scheduler: RTL

- Decode-stage scheduler for the multi-cycle FPU.
- Consumes the decoded fpu_dispatch / fpu_reg_write controls plus register indices, and keeps a per-f-register pending scoreboard and a writeback-slot shift register.
- Stalls decode on RAW, WAW and writeback-port collisions; issues FPU ops and announces their writeback cycle.

---
 rtl/fpu_issue_scheduler_pkg.sv | 20 ++
 rtl/fpu_issue_scheduler_if.sv | 43 ++++
 rtl/fpu_issue_scheduler_wb_shift.sv | 27 ++
 rtl/fpu_issue_scheduler.sv | 85 ++++++++
 4 files changed

// File: rtl/fpu_issue_scheduler_pkg.sv
// Shared constants and slot type for the FPU issue scheduler.
package fpu_sched_pkg;
  localparam int NREG    = 32;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = 4;
  localparam int RD_W    = 5;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            freg;
  } fpu_slot_t;

  // Zero-latency requests still need one cycle; oversize requests saturate.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0) return LAT_W'(1);
    if (lat > LAT_W'(MAX_LAT)) return LAT_W'(MAX_LAT);
    return lat;
  endfunction
endpackage

// File: rtl/fpu_issue_scheduler_if.sv
// Decode <-> FPU scheduler signal bundle. fwd_sel exists only with FPU_FWD_EN.
interface fpu_issue_scheduler_if;
  import fpu_sched_pkg::*;

  logic             dec_valid;
  logic             dec_fpu_dispatch;
  logic             dec_fpu_reg_write;
  logic [RD_W-1:0]  dec_rd;
  logic [RD_W-1:0]  dec_rs1;
  logic [RD_W-1:0]  dec_rs2;
  logic [RD_W-1:0]  dec_rs3;
  logic [2:0]       dec_rs_use;
  logic [LAT_W-1:0] dec_lat;
  logic             flush;
  logic             stall_dec;
  logic             issue;
  logic             wb_valid;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_freg;
  logic [NREG-1:0]  busy;
  logic             fpu_idle;
`ifdef FPU_FWD_EN
  logic [2:0]       fwd_sel;
`endif

  modport master (
    output dec_valid, dec_fpu_dispatch, dec_fpu_reg_write, dec_rd,
           dec_rs1, dec_rs2, dec_rs3, dec_rs_use, dec_lat, flush,
`ifdef FPU_FWD_EN
    input  fwd_sel,
`endif
    input  stall_dec, issue, wb_valid, wb_rd, wb_freg, busy, fpu_idle
  );

  modport slave (
    input  dec_valid, dec_fpu_dispatch, dec_fpu_reg_write, dec_rd,
           dec_rs1, dec_rs2, dec_rs3, dec_rs_use, dec_lat, flush,
`ifdef FPU_FWD_EN
    output fwd_sel,
`endif
    output stall_dec, issue, wb_valid, wb_rd, wb_freg, busy, fpu_idle
  );
endinterface

// File: rtl/fpu_issue_scheduler_wb_shift.sv
// Writeback slot shift register: slot[k] moves to slot[k-1] each edge, slot[1] is the wb stage.
module fpu_wb_shift
  import fpu_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_en,
  input  logic [LAT_W-1:0]        ld_idx,
  input  fpu_slot_t               ld_slot,
  output fpu_slot_t [MAX_LAT:1]   slot_q
);
  fpu_slot_t [MAX_LAT:1] slot_d;

  always_comb begin
    slot_d = '0;
    for (int k = 1; k < MAX_LAT; k++) slot_d[k] = slot_q[k+1];
    // Load overrides the shifted-in entry; the scheduler guarantees that entry is empty.
    if (ld_en)
      for (int k = 1; k <= MAX_LAT; k++)
        if (ld_idx == LAT_W'(k)) slot_d[k] = ld_slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end
endmodule

// File: rtl/fpu_issue_scheduler.sv
// Decode-stage FPU scheduler: pending-write scoreboard, RAW/WAW/wb-port stalls, issue.
// Optional FPU_FWD_EN lets a dependent issue during its producer's writeback cycle.
module fpu_issue_scheduler
  import fpu_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fpu_issue_scheduler_if.slave bus
);
  fpu_slot_t [MAX_LAT:1]   slot_q;
  fpu_slot_t               ld_slot;
  logic [NREG-1:0]         busy_q, busy_d;
  logic [LAT_W-1:0]        eff_lat;
  logic [2:0][RD_W-1:0]    rs;
  logic                    live, raw, waw, wb_clash, stall, iss, any_valid;
`ifdef FPU_FWD_EN
  logic [2:0]              fwd;
`endif

  assign eff_lat = clamp_lat(bus.dec_lat);
  assign rs      = {bus.dec_rs3, bus.dec_rs2, bus.dec_rs1};
  assign live    = bus.dec_valid & ~bus.flush;
  assign ld_slot = {1'b1, bus.dec_rd, bus.dec_fpu_reg_write};

  always_comb begin
    raw      = 1'b0;
    wb_clash = 1'b0;
`ifdef FPU_FWD_EN
    fwd = '0;
`endif
    for (int i = 0; i < 3; i++) begin
`ifdef FPU_FWD_EN
      // The value on the wb bus this cycle can be bypassed, so it is no longer a hazard.
      fwd[i] = bus.dec_rs_use[i] & slot_q[1].valid & slot_q[1].freg & (rs[i] == slot_q[1].rd);
      if (bus.dec_rs_use[i] & busy_q[rs[i]] & ~fwd[i]) raw = 1'b1;
`else
      if (bus.dec_rs_use[i] & busy_q[rs[i]]) raw = 1'b1;
`endif
    end
    // slot[eff_lat+1] lands in slot[eff_lat] on this edge: a second result for the same wb cycle.
    for (int k = 1; k < MAX_LAT; k++)
      if (eff_lat == LAT_W'(k) && slot_q[k+1].valid) wb_clash = 1'b1;
  end

  assign waw   = bus.dec_fpu_dispatch & bus.dec_fpu_reg_write & busy_q[bus.dec_rd];
  assign stall = live & (raw | waw | (bus.dec_fpu_dispatch & wb_clash));
  assign iss   = live & bus.dec_fpu_dispatch & ~stall;

  always_comb begin
    busy_d = busy_q;
    if (slot_q[1].valid & slot_q[1].freg) busy_d[slot_q[1].rd] = 1'b0;
    // Set after clear so a same-register collision keeps the new writer pending.
    if (iss & bus.dec_fpu_reg_write) busy_d[bus.dec_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  fpu_wb_shift u_wb_shift (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (iss),
    .ld_idx  (eff_lat),
    .ld_slot (ld_slot),
    .slot_q  (slot_q)
  );

  always_comb begin
    any_valid = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) any_valid = any_valid | slot_q[k].valid;
  end

  assign bus.stall_dec = stall;
  assign bus.issue     = iss;
  assign bus.wb_valid  = slot_q[1].valid;
  assign bus.wb_rd     = slot_q[1].rd;
  assign bus.wb_freg   = slot_q[1].freg;
  assign bus.busy      = busy_q;
  assign bus.fpu_idle  = ~any_valid;
`ifdef FPU_FWD_EN
  assign bus.fwd_sel   = iss ? fwd : 3'b000;
`endif
endmodule
